// File: rtl/pipelined_alu.sv
// Pipelined ALU: ADD/SUB/logic/MOV/PASS (+ LSL/LSR/ASR when PIPELINED_ALU_SHIFT_EN) with N/Z/C/V flags and tag sideband.
// Latency LATENCY cycles from accept to outValid; consumer stall (outReady low) freezes every stage and drops inReady.
module pipelined_alu #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               inValid,
  output logic               inReady,
  input  logic [WIDTH-1:0]   inOne,
  input  logic [WIDTH-1:0]   inTwo,
  input  logic [3:0]         opcode,
  input  logic               invertZeroFlag,
  input  logic [TAG_W-1:0]   inTag,
  output logic               outValid,
  input  logic               outReady,
  output logic [WIDTH-1:0]   result,
  output logic               zeroFlag,
  output logic               carryBit,
  output logic               negFlag,
  output logic               ovfFlag,
  output logic               illegalOp,
  output logic [TAG_W-1:0]   outTag
);

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_MOV  = 4'b1101;
  localparam logic [3:0] OP_PASS = 4'b0111;
`ifdef PIPELINED_ALU_SHIFT_EN
  localparam logic [3:0] OP_LSL  = 4'b0000;
  localparam logic [3:0] OP_LSR  = 4'b0001;
  localparam logic [3:0] OP_ASR  = 4'b0011;
`endif

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] res;
    logic             z;
    logic             c;
    logic             n;
    logic             v;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t           stage_d;
  stage_t           stage_q [LATENCY];
  logic             adv;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  assign adv     = !stage_q[LATENCY-1].vld || outReady;
  assign inReady = adv;

  assign sum  = {1'b0, inOne} + {1'b0, inTwo};
  assign diff = {1'b0, inOne} - {1'b0, inTwo};

`ifdef PIPELINED_ALU_SHIFT_EN
  // One guard bit beside the operand catches the last bit shifted out as carry.
  logic        [WIDTH:0] lsl_ext;
  logic        [WIDTH:0] lsr_ext;
  logic signed [WIDTH:0] asr_ext;

  assign lsl_ext = {1'b0, inOne} << inTwo;
  assign lsr_ext = {inOne, 1'b0} >> inTwo;
  assign asr_ext = $signed({inOne, 1'b0}) >>> inTwo;
`endif

  always_comb begin
    stage_d     = '0;
    stage_d.vld = inValid;
    stage_d.tag = inTag;
    case (opcode)
      OP_ADD: begin
        stage_d.res = sum[WIDTH-1:0];
        stage_d.c   = sum[WIDTH];
        stage_d.v   = (inOne[WIDTH-1] == inTwo[WIDTH-1]) && (sum[WIDTH-1] != inOne[WIDTH-1]);
      end
      OP_SUB: begin
        stage_d.res = diff[WIDTH-1:0];
        stage_d.c   = diff[WIDTH];
        stage_d.v   = (inOne[WIDTH-1] != inTwo[WIDTH-1]) && (diff[WIDTH-1] != inOne[WIDTH-1]);
      end
      OP_AND:  stage_d.res = inOne & inTwo;
      OP_OR:   stage_d.res = inOne | inTwo;
      OP_XOR:  stage_d.res = inOne ^ inTwo;
      OP_NOR:  stage_d.res = ~(inOne | inTwo);
      OP_NAND: stage_d.res = ~(inOne & inTwo);
      OP_MOV:  stage_d.res = inOne;
      OP_PASS: stage_d.res = inTwo;
`ifdef PIPELINED_ALU_SHIFT_EN
      OP_LSL:  {stage_d.c, stage_d.res} = lsl_ext;
      OP_LSR:  {stage_d.res, stage_d.c} = lsr_ext;
      OP_ASR:  {stage_d.res, stage_d.c} = asr_ext;
`endif
      default: stage_d.ill = 1'b1;
    endcase
    stage_d.z = (stage_d.res == '0) ^ invertZeroFlag;
    stage_d.n = stage_d.res[WIDTH-1];
  end

  // Stage 0 computes; the remaining stages are a plain delay line that moves only on adv.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else if (adv) begin
      stage_q[0] <= stage_d;
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign outValid  = stage_q[LATENCY-1].vld;
  assign result    = stage_q[LATENCY-1].res;
  assign zeroFlag  = stage_q[LATENCY-1].z;
  assign carryBit  = stage_q[LATENCY-1].c;
  assign negFlag   = stage_q[LATENCY-1].n;
  assign ovfFlag   = stage_q[LATENCY-1].v;
  assign illegalOp = stage_q[LATENCY-1].ill;
  assign outTag    = stage_q[LATENCY-1].tag;

endmodule

// File: tb/tb_pipelined_alu.sv
// Bench for pipelined_alu: directed literal cases, back-to-back stall, mid-stream reset and random traffic,
// all outputs compared every valid cycle against a queue-based behavioural model (shift cases follow PIPELINED_ALU_SHIFT_EN).
module tb_pipelined_alu;
  localparam int WIDTH   = 32;
  localparam int LATENCY = 2;
  localparam int TAG_W   = 5;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic              clock = 1'b0;
  logic              resetN = 1'b1;
  logic              inValid = 1'b0;
  logic              inReady;
  logic [WIDTH-1:0]  inOne = '0;
  logic [WIDTH-1:0]  inTwo = '0;
  logic [3:0]        opcode = '0;
  logic              invertZeroFlag = 1'b0;
  logic [TAG_W-1:0]  inTag = '0;
  logic              outValid;
  logic              outReady = 1'b1;
  logic [WIDTH-1:0]  result;
  logic              zeroFlag, carryBit, negFlag, ovfFlag, illegalOp;
  logic [TAG_W-1:0]  outTag;

  pipelined_alu #(.WIDTH(WIDTH), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady),
    .inOne(inOne), .inTwo(inTwo), .opcode(opcode), .invertZeroFlag(invertZeroFlag),
    .inTag(inTag), .outValid(outValid), .outReady(outReady), .result(result),
    .zeroFlag(zeroFlag), .carryBit(carryBit), .negFlag(negFlag), .ovfFlag(ovfFlag),
    .illegalOp(illegalOp), .outTag(outTag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        z, c, n, v, ill;
    logic [4:0]  tag;
    int          cyc;
    int          stalls;
    bit          seen;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stalls = 0;
  int popped = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference semantics straight from the operation table; shifts done one bit at a time.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic inv, input logic [4:0] tag);
    exp_t e;
    logic [63:0] ua, ub, s;
    longint sa, sb, sr;
    logic [31:0] x;
    int amt;
    e = '{default: '0};
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    x = a;
    amt = (b > 32'd33) ? 33 : int'(b);
    case (op)
      4'b0010: begin s = ua + ub; e.res = s[31:0]; e.c = s[32]; sr = sa + sb; e.v = (sr > SMAX) || (sr < SMIN); end
      4'b1010: begin s = ua - ub; e.res = s[31:0]; e.c = (ua < ub); sr = sa - sb; e.v = (sr > SMAX) || (sr < SMIN); end
      4'b0110: e.res = a & b;
      4'b0100: e.res = a | b;
      4'b1001: e.res = a ^ b;
      4'b0101: e.res = ~(a | b);
      4'b1100: e.res = ~(a & b);
      4'b1101: e.res = a;
      4'b0111: e.res = b;
`ifdef PIPELINED_ALU_SHIFT_EN
      4'b0000: begin for (int i = 0; i < amt; i++) begin e.c = x[31]; x = x << 1; end e.res = x; end
      4'b0001: begin for (int i = 0; i < amt; i++) begin e.c = x[0]; x = x >> 1; end e.res = x; end
      4'b0011: begin for (int i = 0; i < amt; i++) begin e.c = x[0]; x = {x[31], x[31:1]}; end e.res = x; end
`endif
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 32'd0) ^ inv;
    e.n = e.res[31];
    e.tag = tag;
    return e;
  endfunction

  // Compare process: negedge sampling, handshakes resolved as they will happen at the next rising edge.
  always @(negedge clock) begin
    if (!resetN) begin
      q.delete();
    end else begin
      cyc++;
      check("in_ready", 64'(inReady), 64'(!outValid || outReady));
      if (outValid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: outValid=1 tag=%h result=%h with nothing expected", outTag, result);
        end else begin
          check("out", 64'({result, zeroFlag, carryBit, negFlag, ovfFlag, illegalOp, outTag}),
                64'({q[0].res, q[0].z, q[0].c, q[0].n, q[0].v, q[0].ill, q[0].tag}));
          if (!q[0].seen) begin
            q[0].seen = 1'b1;
            if (q[0].stalls == stalls) check("latency", 64'(cyc - q[0].cyc), 64'(LATENCY));
          end
          if (outReady) begin
            void'(q.pop_front());
            popped++;
          end else begin
            stalls++;
          end
        end
      end
      if (inValid && inReady) begin
        mon_e = model(opcode, inOne, inTwo, invertZeroFlag, inTag);
        mon_e.cyc = cyc;
        mon_e.stalls = stalls;
        mon_e.seen = 1'b0;
        q.push_back(mon_e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the op. inValid left high.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic inv, input logic [4:0] tag);
    bit acc;
    int n;
    inValid = 1'b1; opcode = op; inOne = a; inTwo = b; invertZeroFlag = inv; inTag = tag;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clock);
      acc = inReady;
      @(posedge clock);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: inReady stayed 0 for %0d cycles", n);
    end
  endtask

  task automatic directed(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic inv, input logic [4:0] tag, input logic [31:0] r,
                          input logic z, input logic c, input logic n, input logic v, input logic ill);
    int k;
    send(op, a, b, inv, tag);
    inValid = 1'b0;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!outValid && k < 20);
    check(name, 64'({outValid, result, zeroFlag, carryBit, negFlag, ovfFlag, illegalOp, outTag}),
          64'({1'b1, r, z, c, n, v, ill, tag}));
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int k;
    bit acc;
    #2 resetN = 1'b0;
    #1;
    check("reset_outputs", 64'({outValid, result, zeroFlag, carryBit, negFlag, ovfFlag, illegalOp, outTag}), 64'(0));
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    @(negedge clock);
    check("reset_inready", 64'({inReady, outValid}), 64'(2'b10));
    @(posedge clock);
    #1;

    // ADD wrap with exact latency.
    send(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5'd3);
    inValid = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) begin
      @(negedge clock);
      check("add_early", 64'(outValid), 64'(0));
    end
    @(negedge clock);
    check("add_wrap", 64'({outValid, result, zeroFlag, carryBit, negFlag, ovfFlag, illegalOp, outTag}),
          64'({1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3}));
    @(posedge clock);
    #1;

    directed("sub_borrow", 4'b1010, 32'h5, 32'h7, 1'b0, 5'd4, 32'hFFFF_FFFE, 0, 1, 1, 0, 0);
    directed("sub_ovf", 4'b1010, 32'h8000_0000, 32'h1, 1'b0, 5'd5, 32'h7FFF_FFFF, 0, 0, 0, 1, 0);
    directed("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b0, 5'd6, 32'h8000_0000, 0, 0, 1, 1, 0);
`ifdef PIPELINED_ALU_SHIFT_EN
    directed("asr_40", 4'b0011, 32'h8000_0000, 32'd40, 1'b0, 5'd7, 32'hFFFF_FFFF, 0, 1, 1, 0, 0);
    directed("lsl_31", 4'b0000, 32'h1, 32'd31, 1'b0, 5'd8, 32'h8000_0000, 0, 0, 1, 0, 0);
    directed("lsr_1", 4'b0001, 32'h3, 32'd1, 1'b0, 5'd9, 32'h1, 0, 1, 0, 0, 0);
`else
    directed("lsl_disabled", 4'b0000, 32'h1, 32'd31, 1'b0, 5'd8, 32'h0, 1, 0, 0, 0, 1);
`endif
    directed("pass_zinv", 4'b0111, 32'h1234_5678, 32'h0, 1'b1, 5'd10, 32'h0, 0, 0, 0, 0, 0);
    directed("illegal_f", 4'b1111, 32'hDEAD_BEEF, 32'h1, 1'b0, 5'd11, 32'h0, 1, 0, 0, 0, 1);
    directed("nand", 4'b1100, 32'hF0F0_FFFF, 32'h0FF0_FFFF, 1'b0, 5'd12, 32'hFF0F_0000, 0, 0, 1, 0, 0);

    // Eight back-to-back ops with the consumer stalling for three cycles.
    base = popped;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(4'b0010, 32'(i * 1000), 32'(i + 1), 1'b0, 5'(16 + i));
        inValid = 1'b0;
      end
      begin
        repeat (3) @(posedge clock);
        #1 outReady = 1'b0;
        repeat (3) @(posedge clock);
        #1 outReady = 1'b1;
      end
    join
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("b2b_count", 64'(popped - base), 64'(8));

    // Mid-stream reset with two ops in flight.
    @(posedge clock);
    #1;
    send(4'b0100, 32'h1, 32'h2, 1'b0, 5'd1);
    send(4'b0100, 32'h4, 32'h8, 1'b0, 5'd2);
    inValid = 1'b0;
    #2 resetN = 1'b0;
    #1;
    check("rst_mid", 64'({outValid, result, outTag}), 64'(0));
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("rst_no_stale", 64'({inReady, outValid}), 64'(2'b10));
    end
    @(posedge clock);
    #1;

    // Random traffic with random consumer backpressure.
    acc = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!inValid || acc) begin
        inValid = ($urandom_range(0, 9) < 7);
        opcode = 4'($urandom_range(0, 15));
        inOne = pick();
        inTwo = pick();
        if ((opcode == 4'b0000 || opcode == 4'b0001 || opcode == 4'b0011) && $urandom_range(0, 1) == 1)
          inTwo = 32'($urandom_range(0, 40));
        invertZeroFlag = 1'($urandom_range(0, 1));
        inTag = 5'($urandom);
      end
      outReady = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      acc = inValid && inReady;
      @(posedge clock);
      #1;
    end
    inValid = 1'b0;
    outReady = 1'b1;
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("drain_empty", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_alu.md
# pipelined_alu

Parametrised, pipelined successor to the single-issue ALU: accepts one operation per clock through a valid/ready handshake, computes arithmetic, logic and (optionally) shift results at configurable data width, and delivers result plus full N/Z/C/V flags after a fixed, configurable latency. It sits between Decoder & Control and the Data Cache / writeback path. Backpressure from the consumer stalls the whole pipeline without loss or duplication of operations.

## Interface
- WIDTH, 32: operand/result width in bits; any value ≥ 8.
- LATENCY, 2: pipeline stages from accept to result; legal range 1..4.
- TAG_W, 5: width of the sideband tag carried alongside each operation.
- clock  input  1  main clock; all state changes on rising edge.
- resetN  input  1  asynchronous, active-low reset.
- inValid  input  1  operation presented this cycle.
- inReady  output  1  block can accept this cycle.
- inOne  input  WIDTH  operand A.
- inTwo  input  WIDTH  operand B / shift amount.
- opcode  input  4  operation select.
- invertZeroFlag  input  1  invert sense of zeroFlag for this operation.
- inTag  input  TAG_W  sideband tag, returned unchanged.
- outValid  output  1  result valid.
- outReady  input  1  consumer accepts result.
- result  output  WIDTH  operation result.
- zeroFlag, carryBit, negFlag, ovfFlag  output  1 each  flags for result.
- illegalOp  output  1  opcode was undefined (or disabled shift).
- outTag  output  TAG_W  tag of the operation on the output.

## Operation
- Opcodes: 0010 ADD; 1010 SUB (inOne − inTwo); 0110 AND; 0100 OR; 1001 XOR; 0101 NOR (bitwise); 1100 NAND (bitwise); 1101 MOV (inOne); 0111 PASS (inTwo, CBZ); 0000 LSL; 0001 LSR; 0011 ASR; all others undefined.
- Shifts: amount = inTwo interpreted unsigned; amount ≥ WIDTH gives 0 for LSL/LSR, all-sign-bits for ASR. carryBit = last bit shifted out (0 if amount = 0; 0 for LSL/LSR when amount > WIDTH).
- ADD: carryBit = bit WIDTH of the (WIDTH+1)-bit sum. SUB: carryBit = 1 iff inOne < inTwo unsigned (borrow).
- ovfFlag: signed overflow for ADD/SUB; 0 for all other ops. negFlag = result[WIDTH-1].
- zeroFlag = (result == 0) XOR invertZeroFlag, evaluated on the produced result.
- Logic/MOV/PASS: carryBit = 0.
- Undefined opcode: result 0, carryBit/ovfFlag/negFlag 0, zeroFlag = 1 XOR invertZeroFlag, illegalOp = 1; operation still flows and handshakes normally.
- Stage 1 computes and registers all outputs; stages 2..LATENCY are pure delay registers with a per-stage valid bit.
- Advance condition adv = !outValid || outReady; when adv, every stage shifts one place, stage 1 loads if inValid. inReady = adv.
- When !adv, all stages hold; presented input is not accepted.

## Timing
- Reset (resetN low, asynchronous): all stage valids 0, outValid 0, result 0, all flags 0, illegalOp 0, outTag 0; inReady = 1 once resetN high.
- Latency: op accepted at edge k appears with outValid = 1 after edge k+LATENCY−1, i.e. visible LATENCY cycles after the accept cycle, with outReady held high.
- Throughput: one op/cycle with outReady continuously high; no bubbles inserted.
- Output stable (result, flags, tag) while outValid && !outReady.
- Simultaneous output accept and input accept in one cycle is legal and required at full rate.
- Bubbles (inValid low) propagate as empty stages; empty stages never stall the pipeline beyond the adv rule.
- resetN asserted mid-stream: all in-flight operations discarded, no partial result emitted.

## Configuration
- PIPELINED_ALU_SHIFT_EN defined: LSL/LSR/ASR implemented as above.
- Undefined: opcodes 0000/0001/0011 treated as undefined (result 0, illegalOp 1); no barrel shifter synthesised.

## Test plan
- Reset then ADD 0xFFFFFFFF + 0x00000001, tag 3, LATENCY=2 -> outValid two cycles later, result 0, carryBit 1, zeroFlag 1, ovfFlag 0, outTag 3.
- SUB 0x00000005 − 0x00000007 -> result 0xFFFFFFFE, carryBit 1, negFlag 1; SUB 0x80000000 − 1 -> result 0x7FFFFFFF, ovfFlag 1.
- Back-to-back 8 ops, outReady low cycles 3–5 -> inReady low while output held, all 8 results emerge in order, none lost or duplicated, stalled output bits unchanged.
- With macro: ASR 0x80000000 by 40 -> 0xFFFFFFFF; LSL 0x1 by 31 -> 0x80000000, carryBit 0; without macro: LSL -> result 0, illegalOp 1.
- PASS inTwo = 0 with invertZeroFlag = 1 -> zeroFlag 0; opcode 1111 -> result 0, illegalOp 1.
- resetN pulsed low with 2 ops in flight -> outValid drops immediately, no stale result after release.
